// File: rtl/ibex_rf_pkg.sv
// ibex_rf_pkg: register-file FSM state type, word counts and address helper.
// Shared by ibex_register_file_mp_fpga and ibex_rf_wr_decode.
package ibex_rf_pkg;

    typedef enum logic {
        RF_INIT,
        RF_READY
    } rf_state_e;

    localparam int NUM_WORDS_RV32E = 16;
    localparam int NUM_WORDS_RV32I = 32;

    // A word address is backed by storage only if nonzero and in range
    function automatic logic addr_legal(logic [4:0] addr, int num_words);
        return (addr != 5'd0) && (int'(addr) < num_words);
    endfunction

endpackage

// File: rtl/ibex_rf_wr_decode.sv
// ibex_rf_wr_decode: two write ports plus init clear -> per-word strobe and data.
// Port A has priority; word 0 has no strobe.
module ibex_rf_wr_decode
    import ibex_rf_pkg::*;
#(
    parameter int                   NumWords    = NUM_WORDS_RV32I,
    parameter int                   DataWidth   = 32,
    parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
    input  logic                                init,
    input  logic [4:0]                          clear_addr,
    input  logic [4:0]                          waddr_a,
    input  logic [DataWidth-1:0]                wdata_a,
    input  logic                                we_a,
    input  logic [4:0]                          waddr_b,
    input  logic [DataWidth-1:0]                wdata_b,
    input  logic                                we_b,
    output logic [NumWords-1:1]                 strobe,
    output logic [NumWords-1:1][DataWidth-1:0]  wdata
);

    always_comb begin
        strobe = '0;
        wdata  = '0;
        for (int i = 1; i < NumWords; i++) begin
            if (init) begin
                strobe[i] = (clear_addr == 5'(i));
                wdata[i]  = WordZeroVal;
            end else if (we_a && (waddr_a == 5'(i))) begin
                strobe[i] = 1'b1;
                wdata[i]  = wdata_a;
            end else if (we_b && (waddr_b == 5'(i))) begin
                strobe[i] = 1'b1;
                wdata[i]  = wdata_b;
            end
        end
    end

endmodule

// File: rtl/ibex_register_file_mp_fpga.sv
// ibex_register_file_mp_fpga: multi-port register file with hardware clear on reset.
// Define IBEX_RF_WRITE_FORWARD_EN to bypass same-cycle write data to reads.
module ibex_register_file_mp_fpga
    import ibex_rf_pkg::*;
#(
    parameter bit                   RV32E        = 1'b0,
    parameter int                   DataWidth    = 32,
    parameter int                   NumReadPorts = 2,
    parameter bit                   WrenCheck    = 1'b0,
    parameter logic [DataWidth-1:0] WordZeroVal  = '0
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumReadPorts*5-1:0]         raddr_i,
    output logic [NumReadPorts*DataWidth-1:0] rdata_o,
    input  logic [4:0]                        waddr_a_i,
    input  logic [DataWidth-1:0]              wdata_a_i,
    input  logic                              we_a_i,
    input  logic [4:0]                        waddr_b_i,
    input  logic [DataWidth-1:0]              wdata_b_i,
    input  logic                              we_b_i,
    output logic                              ready_o,
    output logic                              wr_conflict_o,
    output logic                              err_o
);

    localparam int         NumWords = RV32E ? NUM_WORDS_RV32E : NUM_WORDS_RV32I;
    localparam int         AW       = $clog2(NumWords);
    localparam logic [4:0] LastWord = 5'(NumWords - 1);

    rf_state_e                         state;
    logic [4:0]                        count;
    logic                              ready;
    logic                              init;
    logic                              err;
    logic [NumWords-1:1]               strobe;
    logic [NumWords-1:1][DataWidth-1:0] wdata;
    logic [DataWidth-1:0]              mem [1:NumWords-1];

    assign init = (state == RF_INIT);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= RF_INIT;
            count <= 5'd1;
            ready <= 1'b0;
        end else begin
            case (state)
                RF_INIT: begin
                    if (count == LastWord) begin
                        state <= RF_READY;
                        ready <= 1'b1;
                    end else begin
                        count <= count + 5'd1;
                    end
                end
                RF_READY: state <= RF_READY;
            endcase
        end
    end

    ibex_rf_wr_decode #(
        .NumWords    (NumWords),
        .DataWidth   (DataWidth),
        .WordZeroVal (WordZeroVal)
    ) u_dec (
        .init       (init),
        .clear_addr (count),
        .waddr_a    (waddr_a_i),
        .wdata_a    (wdata_a_i),
        .we_a       (we_a_i),
        .waddr_b    (waddr_b_i),
        .wdata_b    (wdata_b_i),
        .we_b       (we_b_i),
        .strobe     (strobe),
        .wdata      (wdata)
    );

    // Reset blocks every write, including the clear of the current word
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            for (int i = 1; i < NumWords; i++) begin
                if (strobe[i]) mem[i] <= wdata[i];
            end
        end
    end

    for (genvar p = 0; p < NumReadPorts; p++) begin : g_read
        logic [4:0]           addr;
        logic [AW-1:0]        idx;
        logic [DataWidth-1:0] data;

        assign addr = raddr_i[5*p +: 5];
        assign idx  = addr[AW-1:0];

        always_comb begin
            data = '0;
            if (!addr_legal(addr, NumWords)) begin
                data = '0;
            end else if (init) begin
                data = WordZeroVal;
`ifdef IBEX_RF_WRITE_FORWARD_EN
            end else if (we_a_i && (waddr_a_i == addr)) begin
                data = wdata_a_i;
            end else if (we_b_i && (waddr_b_i == addr)) begin
                data = wdata_b_i;
`endif
            end else begin
                data = mem[idx];
            end
        end

        assign rdata_o[DataWidth*p +: DataWidth] = data;
    end

    if (WrenCheck) begin : g_chk
        logic [NumWords-1:1]                strobe_chk;
        logic [NumWords-1:1][DataWidth-1:0] wdata_chk;

        ibex_rf_wr_decode #(
            .NumWords    (NumWords),
            .DataWidth   (DataWidth),
            .WordZeroVal (WordZeroVal)
        ) u_dec_chk (
            .init       (init),
            .clear_addr (count),
            .waddr_a    (waddr_a_i),
            .wdata_a    (wdata_a_i),
            .we_a       (we_a_i),
            .waddr_b    (waddr_b_i),
            .wdata_b    (wdata_b_i),
            .we_b       (we_b_i),
            .strobe     (strobe_chk),
            .wdata      (wdata_chk)
        );

        always_comb begin
            err = 1'b0;
            for (int i = 1; i < NumWords; i++) begin
                if (strobe[i] && (!strobe_chk[i] || (wdata[i] != wdata_chk[i]))) begin
                    err = 1'b1;
                end
            end
        end
    end else begin : g_nochk
        assign err = 1'b0;
    end

    assign ready_o       = ready;
    assign err_o         = err;
    assign wr_conflict_o = !init && we_a_i && we_b_i &&
                           (waddr_a_i == waddr_b_i) && (waddr_a_i != 5'd0);

endmodule

// File: tb/tb_ibex_register_file_mp_fpga.sv
// tb_ibex_register_file_mp_fpga: directed bench for an RV32I instance and an
// RV32E instance with integrity check and nonzero clear value.
module tb_ibex_register_file_mp_fpga;

    localparam logic [31:0] ZV = 32'hC0DE_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  raddr;
    logic [63:0] rdata_a, rdata_e;
    logic [4:0]  waddr_a, waddr_b;
    logic [31:0] wdata_a, wdata_b;
    logic        we_a, we_b;
    logic        ready_a, ready_e;
    logic        conf_a, conf_e;
    logic        err_a, err_e;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string       tag;
        int unsigned which;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    ibex_register_file_mp_fpga dut_a (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .raddr_i       (raddr),
        .rdata_o       (rdata_a),
        .waddr_a_i     (waddr_a),
        .wdata_a_i     (wdata_a),
        .we_a_i        (we_a),
        .waddr_b_i     (waddr_b),
        .wdata_b_i     (wdata_b),
        .we_b_i        (we_b),
        .ready_o       (ready_a),
        .wr_conflict_o (conf_a),
        .err_o         (err_a)
    );

    ibex_register_file_mp_fpga #(
        .RV32E       (1'b1),
        .WrenCheck   (1'b1),
        .WordZeroVal (ZV)
    ) dut_e (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .raddr_i       (raddr),
        .rdata_o       (rdata_e),
        .waddr_a_i     (waddr_a),
        .wdata_a_i     (wdata_a),
        .we_a_i        (we_a),
        .waddr_b_i     (waddr_b),
        .wdata_b_i     (wdata_b),
        .we_b_i        (we_b),
        .ready_o       (ready_e),
        .wr_conflict_o (conf_e),
        .err_o         (err_e)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] pick(int unsigned w);
        case (w)
            0: return rdata_a[31:0];
            1: return rdata_a[63:32];
            2: return rdata_e[31:0];
            default: return rdata_e[63:32];
        endcase
    endfunction

    // Both ports of both instances read addr; ea/ee are the expected words
    task automatic rd(string tag, logic [4:0] addr, logic [31:0] ea, logic [31:0] ee);
        exp_t e;
        raddr = {addr, addr};
        for (int p = 0; p < 2; p++) begin
            sb.push_back('{tag, p, ea});
            sb.push_back('{tag, 2 + p, ee});
        end
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("%s_w%0d", e.tag, e.which), pick(e.which), e.exp);
        end
    endtask

    // From the release cycle, count low-ready cycles of each instance
    task automatic count_init(string tag, logic chk_e);
        int n_a = 0;
        int n_e = 0;
        for (int i = 0; i < 40; i++) begin
            if (!ready_a) n_a++;
            if (!ready_e) n_e++;
            if (i == 2) begin
                waddr_a = 5'd6; wdata_a = 32'h66; we_a = 1'b1;
                waddr_b = 5'd6; wdata_b = 32'h77; we_b = 1'b1;
                #1;
                chk({tag, "_conf_init"}, {31'd0, conf_a}, 32'd0);
            end
            if (i == 3) begin
                we_a = 1'b0;
                we_b = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, "_init_len_a"}, 32'(n_a), 32'd31);
        if (chk_e) chk({tag, "_init_len_e"}, 32'(n_e), 32'd15);
    endtask

    initial begin
        logic [31:0] fwd_a, fwd_e;
        rst_n   = 1'b0;
        raddr   = '0;
        waddr_a = '0; wdata_a = '0; we_a = 1'b0;
        waddr_b = '0; wdata_b = '0; we_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        chk("rst_ready_a", {31'd0, ready_a}, 32'd0);
        chk("rst_ready_e", {31'd0, ready_e}, 32'd0);
        chk("rst_err_a", {31'd0, err_a}, 32'd0);
        rd("rst_rd_x5", 5'd5, 32'd0, ZV);

        rst_n = 1'b1;
        count_init("first", 1'b1);

        rd("clr_x0", 5'd0, 32'd0, 32'd0);
        rd("clr_x1", 5'd1, 32'd0, ZV);
        rd("clr_x6", 5'd6, 32'd0, ZV);
        rd("clr_x15", 5'd15, 32'd0, ZV);
        rd("clr_x31", 5'd31, 32'd0, 32'd0);

        waddr_a = 5'd5; wdata_a = 32'hDEAD_BEEF; we_a = 1'b1;
        @(negedge clk);
        we_a = 1'b0;
        rd("wr_x5", 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        waddr_a = 5'd0; wdata_a = 32'hFFFF_FFFF; we_a = 1'b1;
        @(negedge clk);
        we_a = 1'b0;
        rd("wr_x0", 5'd0, 32'd0, 32'd0);

        waddr_a = 5'd7; wdata_a = 32'h11; we_a = 1'b1;
        waddr_b = 5'd7; wdata_b = 32'h22; we_b = 1'b1;
        #1;
        chk("conf_a", {31'd0, conf_a}, 32'd1);
        chk("conf_e", {31'd0, conf_e}, 32'd1);
        @(negedge clk);
        we_a = 1'b0; we_b = 1'b0;
        rd("conf_x7", 5'd7, 32'h11, 32'h11);

        waddr_a = 5'd3; wdata_a = 32'h33; we_a = 1'b1;
        waddr_b = 5'd4; wdata_b = 32'h44; we_b = 1'b1;
        #1;
        chk("noconf_a", {31'd0, conf_a}, 32'd0);
        chk("err_norm_e", {31'd0, err_e}, 32'd0);
        @(negedge clk);
        we_a = 1'b0; we_b = 1'b0;
        rd("dual_x3", 5'd3, 32'h33, 32'h33);
        rd("dual_x4", 5'd4, 32'h44, 32'h44);

        waddr_a = 5'd17; wdata_a = 32'h1717; we_a = 1'b1;
        @(negedge clk);
        we_a = 1'b0;
        rd("e_x17", 5'd17, 32'h1717, 32'd0);
        rd("e_x1", 5'd1, 32'd0, ZV);

`ifdef IBEX_RF_WRITE_FORWARD_EN
        fwd_a = 32'hA5A5;
        fwd_e = 32'hA5A5;
`else
        fwd_a = 32'd0;
        fwd_e = ZV;
`endif
        waddr_a = 5'd9; wdata_a = 32'hA5A5; we_a = 1'b1;
        rd("fwd_x9", 5'd9, fwd_a, fwd_e);
        @(negedge clk);
        we_a = 1'b0;
        rd("post_x9", 5'd9, 32'hA5A5, 32'hA5A5);

        force dut_e.strobe = 15'h0008;
        #1;
        chk("err_forced", {31'd0, err_e}, 32'd1);
        release dut_e.strobe;
        #1;
        chk("err_released", {31'd0, err_e}, 32'd0);
        @(negedge clk);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (9) @(negedge clk);
        rd("mid_init_x5", 5'd5, 32'd0, ZV);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        count_init("restart", 1'b1);
        rd("lost_x5", 5'd5, 32'd0, ZV);
        rd("lost_x3", 5'd3, 32'd0, ZV);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
